regfile_wb_ctrl: RTL

Write-port controller that sits directly in front of the 32x32 register file. It clears every register after reset. It arbitrates the single write port between the ALU writeback and the load/store unit (LSU) writeback using round-robin. It keeps a scoreboard of outstanding loads and raises a hazard/stall to decode on RAW or WAW conflicts.

---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_wb_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults and encodings for the register-file write-port controller.
package regfile_ctrl_pkg;

   localparam int unsigned DEF_NREG = 32;
   localparam int unsigned DEF_AW   = 5;
   localparam int unsigned DEF_DW   = 32;
   localparam logic [31:0] DEF_INIT_VALUE = 32'h0000_0000;

   typedef enum logic {
      StInit = 1'b0,
      StRun  = 1'b1
   } state_e;

   typedef enum logic {
      SrcAlu = 1'b0,
      SrcLsu = 1'b1
   } src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Outstanding-load scoreboard: one bit per register, set on load issue, cleared on the
// register-file write of the returning load data; set wins over clear on the same index.
module regfile_scoreboard
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned NREG = DEF_NREG,
   parameter int unsigned AW   = DEF_AW
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            i_set,
   input  logic [AW-1:0]   i_set_idx,
   input  logic            i_clr,
   input  logic [AW-1:0]   i_clr_idx,
   input  logic [AW-1:0]   i_rs1,
   input  logic [AW-1:0]   i_rs2,
   input  logic [AW-1:0]   i_rd,
   output logic            o_pend_rs1,
   output logic            o_pend_rs2,
   output logic            o_pend_rd,
   output logic [NREG-1:0] o_sb
);

   logic [NREG-1:0] r_sb;
   logic [NREG-1:0] w_sb_d;

   always_comb begin
      w_sb_d = r_sb;
      if (i_clr) begin
         w_sb_d[i_clr_idx] = 1'b0;
      end
      if (i_set && (i_set_idx != '0)) begin
         w_sb_d[i_set_idx] = 1'b1;
      end
      w_sb_d[0] = 1'b0;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_d;
      end
   end

   assign o_pend_rs1 = r_sb[i_rs1] & (i_rs1 != '0);
   assign o_pend_rs2 = r_sb[i_rs2] & (i_rs2 != '0);
   assign o_pend_rd  = r_sb[i_rd]  & (i_rd  != '0);
   assign o_sb       = r_sb;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: post-reset clear, round-robin ALU/LSU arbitration,
// registered write stage and load-hazard detection for decode.
module regfile_wb_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned     NREG       = DEF_NREG,
   parameter int unsigned     AW         = DEF_AW,
   parameter int unsigned     DW         = DEF_DW,
   parameter logic [DW-1:0]   INIT_VALUE = DW'(DEF_INIT_VALUE)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iALU_VALID,
   output logic          oALU_READY,
   input  logic [AW-1:0] iALU_RD,
   input  logic [DW-1:0] iALU_DATA,
   input  logic          iLSU_VALID,
   output logic          oLSU_READY,
   input  logic [AW-1:0] iLSU_RD,
   input  logic [DW-1:0] iLSU_DATA,
   input  logic          iISSUE_LOAD,
   input  logic [AW-1:0] iISSUE_RD,
   input  logic [AW-1:0] iDEC_RS1,
   input  logic [AW-1:0] iDEC_RS2,
   input  logic [AW-1:0] iDEC_RD,
   output logic          oHAZARD,
   output logic          oBUSY,
   output logic          oWE,
   output logic [AW-1:0] oRD,
   output logic [DW-1:0] oWDATA
);

   state_e          r_state, w_state_d;
   logic [AW-1:0]   r_cnt, w_cnt_d;
   src_e            r_rr, w_rr_d;
   logic            r_we, w_we_d;
   logic [AW-1:0]   r_rd, w_rd_d;
   logic [DW-1:0]   r_wdata, w_wdata_d;
   src_e            r_src, w_src_d;

   logic            w_run;
   logic            w_alu_gnt;
   logic            w_lsu_gnt;
   logic            w_pend_rs1, w_pend_rs2, w_pend_rd;
   logic [NREG-1:0] w_sb;

   assign w_run     = (r_state == StRun);
   assign w_alu_gnt = w_run & iALU_VALID & (~iLSU_VALID | (r_rr == SrcAlu));
   assign w_lsu_gnt = w_run & iLSU_VALID & (~iALU_VALID | (r_rr == SrcLsu));

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_rr_d    = r_rr;
      w_we_d    = 1'b0;
      w_rd_d    = '0;
      w_wdata_d = '0;
      w_src_d   = SrcAlu;
      unique case (r_state)
         StInit: begin
            w_we_d    = 1'b1;
            w_rd_d    = r_cnt;
            w_wdata_d = INIT_VALUE;
            w_cnt_d   = r_cnt + AW'(1);
            if (r_cnt == AW'(NREG - 1)) begin
               w_state_d = StRun;
               w_cnt_d   = '0;
            end
         end
         StRun: begin
            if (iALU_VALID && iLSU_VALID) begin
               w_rr_d = (r_rr == SrcAlu) ? SrcLsu : SrcAlu;
            end
            // x0 handshakes complete but leave the idle (x0, zero) write in place.
            if (w_alu_gnt && (iALU_RD != '0)) begin
               w_we_d    = 1'b1;
               w_rd_d    = iALU_RD;
               w_wdata_d = iALU_DATA;
               w_src_d   = SrcAlu;
            end else if (w_lsu_gnt && (iLSU_RD != '0)) begin
               w_we_d    = 1'b1;
               w_rd_d    = iLSU_RD;
               w_wdata_d = iLSU_DATA;
               w_src_d   = SrcLsu;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_state <= StInit;
         r_cnt   <= '0;
         r_rr    <= SrcAlu;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_wdata <= '0;
         r_src   <= SrcAlu;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_rr    <= w_rr_d;
         r_we    <= w_we_d;
         r_rd    <= w_rd_d;
         r_wdata <= w_wdata_d;
         r_src   <= w_src_d;
      end
   end

   // Clear on the edge that performs the write, so a 0 bit means the file already holds the data.
   regfile_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .i_set      (iISSUE_LOAD & w_run),
      .i_set_idx  (iISSUE_RD),
      .i_clr      (r_we & (r_src == SrcLsu)),
      .i_clr_idx  (r_rd),
      .i_rs1      (iDEC_RS1),
      .i_rs2      (iDEC_RS2),
      .i_rd       (iDEC_RD),
      .o_pend_rs1 (w_pend_rs1),
      .o_pend_rs2 (w_pend_rs2),
      .o_pend_rd  (w_pend_rd),
      .o_sb       (w_sb)
   );

   assign oBUSY      = ~w_run;
   assign oHAZARD    = oBUSY | w_pend_rs1 | w_pend_rs2 | w_pend_rd;
   assign oALU_READY = w_alu_gnt;
   assign oLSU_READY = w_lsu_gnt;
   assign oWE        = r_we;
   assign oRD        = r_rd;
   assign oWDATA     = r_wdata;

   alu_wb_to_pending_load: assert property (@(posedge iCLK) disable iff (!iRST)
      !(w_alu_gnt && w_sb[iALU_RD]));

endmodule
